ps2_device_tx: RTL and testbench

PS/2 device-side transmitter. Serialises bytes into standard 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop), driving the clock and data lines itself, as a keyboard does. It is the far end of the PS/2 receive path in `vga_module`. Its `ps2_clk_o` and `ps2_data_o` connect to `ps2_clk_i` and `ps2_data_i`, either in the bench top or on a loopback build.

---
 rtl/ps2_device_tx.sv | 157 +++++++++++++++
 tb/tb_ps2_device_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: sends 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and drives both lines itself. Define PS2_TX_BREAK_EN to prefix a 0xF0 break frame when tx_release is set.
module ps2_device_tx #(
  parameter int HALF_CYC = 2000,
  parameter int GAP_CYC  = 4000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_release,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy,
  output logic       done
);

  localparam int HW = $clog2(HALF_CYC);
  localparam int GW = $clog2(GAP_CYC + 1);
  // Data is loaded one cycle early so it is on the line from the mid-point count onward.
  localparam logic [HW-1:0] HALF_MID  = HW'(HALF_CYC / 2 - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [10:0]   frame;
  logic [3:0]    bit_idx;

`ifdef PS2_TX_BREAK_EN
  logic       pend;
  logic [7:0] pend_data;
`else
  logic unused_release;
  assign unused_release = tx_release;
`endif

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] b);
    return {1'b1, odd_parity(b), b, 1'b0};
  endfunction

  // Frame sequencer with registered line and handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      half_cnt   <= '0;
      gap_cnt    <= '0;
      frame      <= '1;
      bit_idx    <= 4'd0;
      ps2_clk_o  <= 1'b1;
      ps2_data_o <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PS2_TX_BREAK_EN
      pend       <= 1'b0;
      pend_data  <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= HIGH;
            half_cnt <= '0;
            bit_idx  <= 4'd0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef PS2_TX_BREAK_EN
            if (tx_release) begin
              frame     <= make_frame(8'hF0);
              pend      <= 1'b1;
              pend_data <= tx_data;
            end else begin
              frame     <= make_frame(tx_data);
              pend      <= 1'b0;
            end
`else
            frame    <= make_frame(tx_data);
`endif
          end
        end
        HIGH: begin
          if (half_cnt == HALF_MID) begin
            ps2_data_o <= frame[0];
          end
          if (half_cnt == HALF_LAST) begin
            state     <= LOW;
            half_cnt  <= '0;
            ps2_clk_o <= 1'b0;
          end else begin
            half_cnt  <= half_cnt + HW'(1);
          end
        end
        LOW: begin
          if (half_cnt == HALF_LAST) begin
            ps2_clk_o <= 1'b1;
            half_cnt  <= '0;
            if (bit_idx == 4'd10) begin
              state      <= GAP;
              gap_cnt    <= '0;
              done       <= 1'b1;
              ps2_data_o <= 1'b1;
            end else begin
              state   <= HIGH;
              bit_idx <= bit_idx + 4'd1;
              frame   <= {1'b1, frame[10:1]};
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
`ifdef PS2_TX_BREAK_EN
            // The held byte follows the break frame without reopening the handshake.
            if (pend) begin
              state    <= HIGH;
              half_cnt <= '0;
              bit_idx  <= 4'd0;
              frame    <= make_frame(pend_data);
              pend     <= 1'b0;
            end else begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end
`else
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
`endif
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          ps2_clk_o  <= 1'b1;
          ps2_data_o <= 1'b1;
          tx_ready   <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a line receiver sampling on clock falling edges is compared
// against frames built from the PS/2 framing rules.
module tb_ps2_device_tx;

  localparam int HALF = 4;
  localparam int GAP  = 8;
  localparam int FRAME_CYC = 22 * HALF;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_release = 1'b0;
  logic       tx_ready, ps2_clk_o, ps2_data_o, busy, done;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  bit exp_bits[$];
  bit rx_bits[$];
  int done_cycs[$];
  int viol = 0;
  logic prev_clk = 1'b1;
  logic prev_data = 1'b1;

  ps2_device_tx #(.HALF_CYC(HALF), .GAP_CYC(GAP)) dut (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_release(tx_release), .ps2_clk_o(ps2_clk_o), .ps2_data_o(ps2_data_o),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Receiver: sample data on clock falls, flag data moving while clock is low, log done pulses.
  always @(negedge CLK) begin
    if (prev_clk === 1'b1 && ps2_clk_o === 1'b0) rx_bits.push_back(ps2_data_o);
    if (prev_clk === 1'b0 && ps2_clk_o === 1'b0 && ps2_data_o !== prev_data) viol = viol + 1;
    if (done === 1'b1) done_cycs.push_back(cyc);
    prev_clk  = ps2_clk_o;
    prev_data = ps2_data_o;
  end

  function automatic void add_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
  endfunction

  function automatic string bits_str(input bit q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, q[i] ? "1" : "0"};
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input string name, output int rc);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    rc = cyc;
    chk_cnt++;
    if (tx_ready !== 1'b1) $display("FAIL %s ready_timeout: tx_ready=%b required 1", name, tx_ready);
    else pass_cnt++;
  endtask

  task automatic wait_done(input string name, input int n);
    int k;
    k = 0;
    while (done_cycs.size() < n && k < 600) begin
      tick();
      k++;
    end
    chk_cnt++;
    if (done_cycs.size() != n) $display("FAIL %s done_count: got %0d required %0d", name, done_cycs.size(), n);
    else pass_cnt++;
  endtask

  task automatic check_bits(input string name);
    chk_cnt++;
    if (rx_bits != exp_bits)
      $display("FAIL %s bits: got %s required %s", name, bits_str(rx_bits), bits_str(exp_bits));
    else pass_cnt++;
    chk_cnt++;
    if (viol != 0) $display("FAIL %s data_while_clk_low: got %0d changes required 0", name, viol);
    else pass_cnt++;
  endtask

  task automatic send_check(input string name, input logic [7:0] b, input logic rel);
    int start, rc, nf;
    exp_bits.delete();
`ifdef PS2_TX_BREAK_EN
    nf = rel ? 2 : 1;
    if (rel) add_frame(8'hF0);
`else
    nf = 1;
`endif
    add_frame(b);
    wait_ready(name, rc);
    rx_bits.delete();
    done_cycs.delete();
    viol = 0;
    tx_data = b; tx_release = rel; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_release = 1'b0;
    start = cyc;
    chk_cnt++;
    if (busy !== 1'b1 || tx_ready !== 1'b0)
      $display("FAIL %s accept: busy=%b tx_ready=%b required 1/0", name, busy, tx_ready);
    else pass_cnt++;
    wait_done(name, nf);
    wait_ready(name, rc);
    if (done_cycs.size() == nf) begin
      chk_cnt++;
      if (done_cycs[0] - start != FRAME_CYC)
        $display("FAIL %s done_latency: got %0d required %0d", name, done_cycs[0] - start, FRAME_CYC);
      else pass_cnt++;
      if (nf == 2) begin
        chk_cnt++;
        if (done_cycs[1] - done_cycs[0] != GAP + FRAME_CYC)
          $display("FAIL %s second_done: got %0d required %0d", name, done_cycs[1] - done_cycs[0], GAP + FRAME_CYC);
        else pass_cnt++;
      end
      chk_cnt++;
      if (rc - done_cycs[nf-1] != GAP)
        $display("FAIL %s ready_after_done: got %0d required %0d", name, rc - done_cycs[nf-1], GAP);
      else pass_cnt++;
    end
    check_bits(name);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_cnt++;
      if ({ps2_clk_o, ps2_data_o, tx_ready, busy, done} !== 5'b11100)
        $display("FAIL reset_idle: clk/data/ready/busy/done=%b%b%b%b%b required 11100",
                 ps2_clk_o, ps2_data_o, tx_ready, busy, done);
      else pass_cnt++;
    end
  endtask

  task automatic test_frames();
    send_check("byte_1c", 8'h1C, 1'b0);
    send_check("byte_ff", 8'hFF, 1'b0);
    send_check("byte_00", 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_check("byte_rand", 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_back_to_back();
    int rc, start1, start2, ready_hi, k;
    bit seen_idle;
    exp_bits.delete();
    add_frame(8'h1C);
    add_frame(8'h32);
    wait_ready("b2b", rc);
    rx_bits.delete(); done_cycs.delete(); viol = 0;
    tx_data = 8'h1C; tx_valid = 1'b1;
    tick();
    start1 = cyc;
    tx_data = 8'h32;
    seen_idle = 1'b0; start2 = -1; ready_hi = 0; k = 0;
    while (start2 < 0 && k < 400) begin
      tick();
      k++;
      if (tx_ready === 1'b1) ready_hi++;
      if (busy === 1'b0) seen_idle = 1'b1;
      else if (seen_idle) start2 = cyc;
    end
    tx_valid = 1'b0;
    chk_cnt++;
    if (ready_hi != 1) $display("FAIL b2b ready_window: got %0d cycles required 1", ready_hi);
    else pass_cnt++;
    wait_done("b2b", 2);
    wait_ready("b2b", rc);
    if (done_cycs.size() == 2) begin
      chk_cnt++;
      if (done_cycs[0] - start1 != FRAME_CYC || start2 - done_cycs[0] != GAP + 1 || done_cycs[1] - start2 != FRAME_CYC)
        $display("FAIL b2b timing: d1-s1=%0d s2-d1=%0d d2-s2=%0d required %0d/%0d/%0d",
                 done_cycs[0] - start1, start2 - done_cycs[0], done_cycs[1] - start2, FRAME_CYC, GAP + 1, FRAME_CYC);
      else pass_cnt++;
    end
    check_bits("b2b");
    repeat (30) tick();
    chk_cnt++;
    if (done_cycs.size() != 2 || busy !== 1'b0)
      $display("FAIL b2b extra_frame: done_count=%0d busy=%b required 2/0", done_cycs.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int rc, start, n;
    wait_ready("midrst", rc);
    tx_data = 8'h1C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    start = cyc;
    repeat (29) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_cnt++;
    if ({ps2_clk_o, ps2_data_o, tx_ready, busy} !== 4'b1110)
      $display("FAIL midrst_state: clk/data/ready/busy=%b%b%b%b required 1110 (cycle %0d)",
               ps2_clk_o, ps2_data_o, tx_ready, busy, cyc - start);
    else pass_cnt++;
    done_cycs.delete();
    repeat (100) tick();
    n = done_cycs.size();
    chk_cnt++;
    if (n != 0) $display("FAIL midrst_done: got %0d pulses required 0", n);
    else pass_cnt++;
    send_check("after_rst_1c", 8'h1C, 1'b0);
  endtask

  task automatic test_break();
    send_check("break_1c", 8'h1C, 1'b1);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_midframe();
    test_break();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
